layer_mixer: RTL
================

// Module: layer_mixer
// PURPOSE
//   Parametrised, pipelined priority compositor between the sprite/text generators and the VGA pins.
//   Merges N_LAYERS RGB layers by fixed priority; an all-zero pixel is transparent.
//   Layer 0 has the highest priority. Layer N_LAYERS-1 is the background and is drawn even when zero.
//   Adds per-frame layer-enable shadowing, sync/valid delay matching and per-frame collision flags for game logic.
// PARAMETERS
//   N_LAYERS    7  number of layers, 2..16
//   COLOR_BITS  3  bits per channel per layer
//   OUT_BITS    4  bits per output channel; must be >= COLOR_BITS
// PORTS
//   clk          in   1                      pixel clock
//   rst_n        in   1                      synchronous reset, active-low
//   valid        in   1                      active-video qualifier for this pixel
//   hsync_in     in   1                      horizontal sync, passed through delayed
//   vsync_in     in   1                      vertical sync, passed through delayed
//   frame_start  in   1                      1-cycle pulse, first cycle of a frame
//   layer_en     in   N_LAYERS               layer enable mask; 1 = layer drawn
//   layer_pix    in   N_LAYERS*3*COLOR_BITS  layer i at [i*3*COLOR_BITS +: 3*COLOR_BITS], packed as {R,G,B}
//   vgaRed       out  OUT_BITS               registered red output
//   vgaGreen     out  OUT_BITS               registered green output
//   vgaBlue      out  OUT_BITS               registered blue output
//   hsync_out    out  1                      hsync_in delayed by 2 cycles
//   vsync_out    out  1                      vsync_in delayed by 2 cycles
//   valid_out    out  1                      valid delayed by 2 cycles
//   coll_flags   out  N_LAYERS               bit i = layer i overlapped another opaque enabled layer in the previous frame
//   coll_valid   out  1                      1-cycle pulse when coll_flags updates
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): all outputs 0, pipeline registers 0.
//     Shadow enable = all ones. Collision accumulator = 0.
//   S1 (stage 1) registers:
//     - layer_pix, valid, hsync_in, vsync_in, frame_start
//     - shadow enable: loads layer_en only on a frame_start cycle; otherwise holds
//   S2 (stage 2) registers the outputs; total latency 2 cycles, every cycle, no stall.
//   Opaque: layer i with i < N_LAYERS-1 is opaque when its S1 pixel != 0 and its shadow enable bit = 1.
//   Selection:
//     - if S1 valid = 0, output is 0
//     - else the lowest-index opaque layer is drawn
//     - if no layer is opaque, the background is drawn if it is enabled, else black
//   Channel expand: out = {c, (OUT_BITS-COLOR_BITS) zeros}. Example: 3'b101 -> 4'b1010.
//   Collision:
//     - evaluated only on S1 valid cycles; only non-background opaque layers count
//     - hit[i] = layer i opaque AND at least one other layer opaque
//     - accumulator |= hit each cycle
//   Frame boundary (S1 frame_start = 1):
//     - coll_flags <= accumulator, excluding this cycle's hits
//     - accumulator <= this cycle's hits; a hit on the first pixel belongs to the new frame
//     - coll_valid = 1 on the same edge as the coll_flags update
//   Mid-frame layer_en changes take effect only at the next frame_start.
//   Reset mid-frame:
//     - the accumulator is discarded and no coll_valid pulse is issued
//     - the first frame_start after reset reports the partial frame
//   frame_start asserted on back-to-back cycles: each pulse ends a frame; a 1-pixel frame is legal.
// CONFIGURATION
//   MIXER_REPLICATE_EN defined:
//     - low output bits filled by replicating the channel MSBs instead of zeros
//     - 3'b101 -> 4'b1011; 3'b111 -> 4'b1111 (full-scale white)
//   MIXER_REPLICATE_EN undefined: zero padding as above.
//   No effect on latency or collision logic.
// TESTING
//   Defaults: N_LAYERS=7, COLOR_BITS=3, OUT_BITS=4.
//   1. rst_n=0 for 3 cycles, inputs random -> all outputs 0.
//      After release, first pixel appears 2 cycles after it is driven.
//   2. Valid pixel: L0=0, L2=9'h1C0, L6=9'h03F -> {R,G,B}=12'hE00.
//      Same with L2=0 -> 12'h0EE.
//      valid=0 -> 12'h000; syncs still delayed by 2.
//   3. layer_en=7'b1111011 driven mid-frame -> L2 still drawn until the next frame_start, then L6 shows.
//      layer_en bit6=0 and no opaque layer -> 12'h000.
//   4. Frame with L3 and L4 opaque together on 5 valid pixels, then frame_start
//      -> coll_valid 1 cycle, coll_flags=7'b0011000. Next empty frame -> 7'b0.
//   5. Overlap on the exact frame_start pixel -> not reported at that boundary; reported at the next one.
//      Overlap with valid=0 -> ignored.
//   6. Build with MIXER_REPLICATE_EN: L0=9'h1FF -> 12'hFFF (without the macro: 12'hEEE).

Source files
------------

// File: rtl/layer_mixer_if.sv
// -----------------------------------------------------------------------------
// layer_mixer_if
//   Bundles the pixel-stream side of layer_mixer: the layer inputs and timing
//   from the sprite/text generators, plus the VGA outputs and collision report.
//
//   Handshake: `valid` qualifies the pixel presented on the same cycle. There
//   is no ready. The mixer accepts a pixel every clock and never stalls, so
//   every output appears exactly 2 cycles after its input, with or without
//   valid.
//
//   Modports
//     master : generator / testbench side (drives inputs, observes outputs)
//     slave  : mixer side (observes inputs, drives outputs)
// -----------------------------------------------------------------------------
interface layer_mixer_if #(
  parameter int N_LAYERS   = 7,
  parameter int COLOR_BITS = 3,
  parameter int OUT_BITS   = 4
);
  logic                           valid;
  logic                           hsync_in;
  logic                           vsync_in;
  logic                           frame_start;
  logic [N_LAYERS-1:0]            layer_en;
  logic [N_LAYERS*3*COLOR_BITS-1:0] layer_pix;
  logic [OUT_BITS-1:0]            vgaRed;
  logic [OUT_BITS-1:0]            vgaGreen;
  logic [OUT_BITS-1:0]            vgaBlue;
  logic                           hsync_out;
  logic                           vsync_out;
  logic                           valid_out;
  logic [N_LAYERS-1:0]            coll_flags;
  logic                           coll_valid;

  modport master (
    output valid, hsync_in, vsync_in, frame_start, layer_en, layer_pix,
    input  vgaRed, vgaGreen, vgaBlue, hsync_out, vsync_out, valid_out,
           coll_flags, coll_valid
  );

  modport slave (
    input  valid, hsync_in, vsync_in, frame_start, layer_en, layer_pix,
    output vgaRed, vgaGreen, vgaBlue, hsync_out, vsync_out, valid_out,
           coll_flags, coll_valid
  );
endinterface

// File: rtl/layer_mixer.sv
// -----------------------------------------------------------------------------
// layer_mixer
//   Two-stage priority compositor between the layer generators and the VGA
//   pins. Layer 0 has the highest priority. An all-zero pixel is transparent,
//   except on the background layer (N_LAYERS-1), which is drawn even when zero.
//   Layer enables are shadowed per frame. Collision flags are reported once per
//   frame.
//
//   Ports
//     clk    : pixel clock
//     rst_n  : synchronous reset, active-low
//     mix    : layer_mixer_if.slave
//              inputs  valid, hsync_in, vsync_in, frame_start, layer_en,
//                      layer_pix (layer i at [i*3*COLOR_BITS +: 3*COLOR_BITS],
//                      packed as {R,G,B})
//              outputs vgaRed/vgaGreen/vgaBlue, hsync_out, vsync_out,
//                      valid_out (all 2 cycles after input), coll_flags,
//                      coll_valid
//
//   Build option
//     MIXER_REPLICATE_EN : fill the low output bits by replicating the channel
//                          MSBs, so full scale maps to full scale. When it is
//                          undefined, the low bits are zero.
// -----------------------------------------------------------------------------
module layer_mixer #(
  parameter int N_LAYERS   = 7,
  parameter int COLOR_BITS = 3,
  parameter int OUT_BITS   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  layer_mixer_if.slave mix
);
  localparam int PW = 3 * COLOR_BITS;
  localparam logic [N_LAYERS-1:0] ONE = N_LAYERS'(1);

  // Stage 1
  logic [N_LAYERS*PW-1:0] r_s1_pix;
  logic                   r_s1_valid;
  logic                   r_s1_hs;
  logic                   r_s1_vs;
  logic                   r_s1_fs;
  logic [N_LAYERS-1:0]    r_shadow_en;
  logic [N_LAYERS-1:0]    r_acc;

  // Stage 2 (outputs)
  logic [OUT_BITS-1:0]    r_red;
  logic [OUT_BITS-1:0]    r_green;
  logic [OUT_BITS-1:0]    r_blue;
  logic                   r_hs_out;
  logic                   r_vs_out;
  logic                   r_valid_out;
  logic [N_LAYERS-1:0]    r_coll_flags;
  logic                   r_coll_valid;

  logic [N_LAYERS-1:0]    w_opaque;
  logic [N_LAYERS-1:0]    w_hit;
  logic [PW-1:0]          w_sel;

  function automatic logic [OUT_BITS-1:0] expand(input logic [COLOR_BITS-1:0] c);
    logic [OUT_BITS-1:0] r;
    r = '0;
    r[OUT_BITS-1 -: COLOR_BITS] = c;
`ifdef MIXER_REPLICATE_EN
    // Copy downward from the top so that wide pads repeat the whole pattern.
    for (int b = OUT_BITS - COLOR_BITS - 1; b >= 0; b--) r[b] = r[b + COLOR_BITS];
`endif
    return r;
  endfunction

  // Opacity and priority selection. The background never counts as opaque.
  always_comb begin
    w_opaque = '0;
    for (int i = 0; i < N_LAYERS - 1; i++)
      w_opaque[i] = (r_s1_pix[i*PW +: PW] != '0) && r_shadow_en[i];

    w_sel = r_shadow_en[N_LAYERS-1] ? r_s1_pix[(N_LAYERS-1)*PW +: PW] : '0;
    // Walk from lowest to highest priority so that the lowest index wins.
    for (int i = N_LAYERS - 2; i >= 0; i--)
      if (w_opaque[i]) w_sel = r_s1_pix[i*PW +: PW];
    if (!r_s1_valid) w_sel = '0;
  end

  // A layer hits when it is opaque and at least one other layer is opaque too.
  always_comb begin
    w_hit = '0;
    if (r_s1_valid)
      for (int i = 0; i < N_LAYERS - 1; i++)
        w_hit[i] = w_opaque[i] && ((w_opaque & ~(ONE << i)) != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_pix     <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_hs      <= 1'b0;
      r_s1_vs      <= 1'b0;
      r_s1_fs      <= 1'b0;
      r_shadow_en  <= '1;
      r_acc        <= '0;
      r_red        <= '0;
      r_green      <= '0;
      r_blue       <= '0;
      r_hs_out     <= 1'b0;
      r_vs_out     <= 1'b0;
      r_valid_out  <= 1'b0;
      r_coll_flags <= '0;
      r_coll_valid <= 1'b0;
    end else begin
      r_s1_pix   <= mix.layer_pix;
      r_s1_valid <= mix.valid;
      r_s1_hs    <= mix.hsync_in;
      r_s1_vs    <= mix.vsync_in;
      r_s1_fs    <= mix.frame_start;
      // The new enables apply from the frame_start pixel itself.
      if (mix.frame_start) r_shadow_en <= mix.layer_en;

      r_red       <= expand(w_sel[PW-1 -: COLOR_BITS]);
      r_green     <= expand(w_sel[2*COLOR_BITS-1 -: COLOR_BITS]);
      r_blue      <= expand(w_sel[COLOR_BITS-1:0]);
      r_hs_out    <= r_s1_hs;
      r_vs_out    <= r_s1_vs;
      r_valid_out <= r_s1_valid;

      // On a frame boundary, report the frame that just ended. Hits on the
      // boundary pixel start the new frame's accumulation.
      r_coll_valid <= r_s1_fs;
      if (r_s1_fs) begin
        r_coll_flags <= r_acc;
        r_acc        <= w_hit;
      end else begin
        r_acc <= r_acc | w_hit;
      end
    end
  end

  assign mix.vgaRed     = r_red;
  assign mix.vgaGreen   = r_green;
  assign mix.vgaBlue    = r_blue;
  assign mix.hsync_out  = r_hs_out;
  assign mix.vsync_out  = r_vs_out;
  assign mix.valid_out  = r_valid_out;
  assign mix.coll_flags = r_coll_flags;
  assign mix.coll_valid = r_coll_valid;
endmodule
